// File: rtl/fsm_01.sv
// Trigger-qualification FSM: rejects short trigger glitches, strobes m_load on each new
// trigger, raises m_alarm on a qualified trigger. Define FSM_01_TRIGGER_SYNC_EN for a 2-flop input synchronizer.
module fsm_01 #(
  parameter int HOLD_CYCLES    = 8,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic m_clk,
  input  logic m_reset,
  input  logic trigger,
  output logic m_load,
  output logic m_alarm
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT,
    S_ALARM,
    S_HOLDOFF
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, alarm_q;
  logic             trg;

`ifdef FSM_01_TRIGGER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge m_clk) begin
    if (m_reset) sync_q <= '0;
    else         sync_q <= {sync_q[0], trigger};
  end

  assign trg = sync_q[1];
`else
  assign trg = trigger;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (trg) begin
          state_d = S_LOAD;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      S_LOAD, S_COUNT: begin
        if (!trg) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_ALARM;
        end else begin
          state_d = S_COUNT;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_ALARM: begin
        if (!trg) begin
          state_d = S_HOLDOFF;
          cnt_d   = HOLDOFF_LAST;
        end
      end
      S_HOLDOFF: begin
        // A re-trigger returns straight to ALARM, so no new m_load strobe is produced.
        if (trg)               state_d = S_ALARM;
        else if (cnt_q == '0)  state_d = S_IDLE;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // Outputs are decoded from the next state into flops, so they line up with the state register.
  always_ff @(posedge m_clk) begin
    if (m_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= (state_d == S_LOAD);
      alarm_q <= (state_d == S_ALARM) || (state_d == S_HOLDOFF);
    end
  end

  assign m_load  = load_q;
  assign m_alarm = alarm_q;

endmodule

// File: tb/tb_fsm_01.sv
// Scoreboard bench for fsm_01: stimulus pushes expected output events (kind, edge number),
// a negedge monitor pops and compares each observed m_load strobe and m_alarm transition.
module tb_fsm_01;

  localparam int HOLD    = 8;
  localparam int HOLDOFF = 4;
`ifdef FSM_01_TRIGGER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef enum int {EV_LOAD, EV_RISE, EV_FALL} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       edge_n;
  } ev_t;

  logic m_clk = 1'b0;
  logic m_reset = 1'b1;
  logic trigger = 1'b0;
  logic m_load;
  logic m_alarm;

  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  bit   mon_en = 1'b0;
  logic alarm_prev = 1'b0;
  ev_t  exp_q[$];

  fsm_01 #(.HOLD_CYCLES(HOLD), .HOLDOFF_CYCLES(HOLDOFF), .CNT_W(8)) dut (
    .m_clk   (m_clk),
    .m_reset (m_reset),
    .trigger (trigger),
    .m_load  (m_load),
    .m_alarm (m_alarm)
  );

  always #5 m_clk = ~m_clk;
  always @(posedge m_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_e kind, input int edge_n);
    ev_t e;
    e.kind   = kind;
    e.edge_n = edge_n;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, expected no event", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", int'(kind), int'(e.kind));
      check("event_edge", cyc, e.edge_n);
    end
  endtask

  always @(negedge m_clk) begin
    if (mon_en) begin
      if (m_load === 1'b1) observe(EV_LOAD);
      if (m_alarm !== alarm_prev) observe(m_alarm === 1'b1 ? EV_RISE : EV_FALL);
      alarm_prev = m_alarm;
    end
  end

  // Clean trigger pulse sampled high on exactly n edges, starting from IDLE.
  task automatic pulse(input int n);
    int s;
    s = cyc + 1;
    expect_ev(EV_LOAD, s + LAT);
    if (n >= HOLD) begin
      expect_ev(EV_RISE, s + HOLD - 1 + LAT);
      expect_ev(EV_FALL, s + n + HOLDOFF + LAT);
    end
    trigger = 1'b1;
    repeat (n) @(negedge m_clk);
    trigger = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge m_clk);
  endtask

  initial begin
    int s;
    int r;
    // Reset held 5 edges with trigger high: outputs must stay low.
    trigger = 1'b1;
    m_reset = 1'b1;
    @(negedge m_clk);
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("reset_load", int'(m_load), 0);
      check("reset_alarm", int'(m_alarm), 0);
      if (i < 4) @(negedge m_clk);
    end
    m_reset = 1'b0;
    s = cyc + 1;
    expect_ev(EV_LOAD, s + LAT);
    @(negedge m_clk);
    @(negedge m_clk);
    trigger = 1'b0;
    idle(8);

    // Long pulse: 30 samples.
    pulse(30);
    idle(12);

    // Short pulse of 2 samples.
    pulse(2);
    idle(6);

    // ~1.5 period pulse offset from the edges: sampled on 2 edges, strobe only.
    s = cyc + 1;
    expect_ev(EV_LOAD, s + LAT);
    #2 trigger = 1'b1;
    #15 trigger = 1'b0;
    @(negedge m_clk);
    idle(6);

    // Pulse entirely between two edges: never sampled, no events.
    #1 trigger = 1'b1;
    #2 trigger = 1'b0;
    @(negedge m_clk);
    idle(6);

    // Boundaries: 7 samples -> no alarm, 8 samples -> alarm.
    pulse(HOLD - 1);
    idle(6);
    pulse(HOLD);
    idle(12);

    // Re-trigger during hold-off: 10 high, 2 low, 5 high; alarm stays continuous.
    s = cyc + 1;
    expect_ev(EV_LOAD, s + LAT);
    expect_ev(EV_RISE, s + HOLD - 1 + LAT);
    expect_ev(EV_FALL, s + 17 + HOLDOFF + LAT);
    trigger = 1'b1;
    idle(10);
    trigger = 1'b0;
    idle(2);
    trigger = 1'b1;
    idle(5);
    trigger = 1'b0;
    idle(12);

    // Reset while in ALARM, trigger kept high across and after reset.
    s = cyc + 1;
    expect_ev(EV_LOAD, s + LAT);
    expect_ev(EV_RISE, s + HOLD - 1 + LAT);
    trigger = 1'b1;
    idle(12);
    r = cyc + 1;
    expect_ev(EV_FALL, r);
    expect_ev(EV_LOAD, r + 1 + LAT);
    m_reset = 1'b1;
    @(negedge m_clk);
    check("midreset_load", int'(m_load), 0);
    check("midreset_alarm", int'(m_alarm), 0);
    m_reset = 1'b0;
    idle(3);
    trigger = 1'b0;
    idle(10);

    check("events_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
